dtile_mem_responder: RTL

Data-tile memory responder servicing load/store requests tagged with a 5-bit LSID. It queues requests in arrival order and performs one data-memory access at a time over a request/grant/read-valid port. For each request it returns a one-cycle completion (`set_complete`/`set_lsid`/`set_data`) to the LSID ordering unit. It sits in the d_tile, between the issuing execution path and the data SRAM/cache.

---
 rtl/dtile_mem_pkg.sv | 24 ++
 rtl/dtile_req_fifo.sv | 53 +++++
 rtl/dtile_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dtile_mem_pkg.sv
// rtl/dtile_mem_pkg.sv - shared types and defaults for the d_tile memory responder
package dtile_mem_pkg;

  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_LSID_W = 5;

  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic                      is_load;
    logic [DEFAULT_LSID_W-1:0] lsid;
    logic [DEFAULT_ADDR_W-1:0] addr;
    reg_data_t                 data;
  } dtile_req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } dtile_rsp_state_e;

endpackage

// File: rtl/dtile_req_fifo.sv
// rtl/dtile_req_fifo.sv - in-order request FIFO with head output, no push/pop bypass
module dtile_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dtile_mem_responder.sv
// rtl/dtile_mem_responder.sv - queued load/store responder, one memory access at a time; optional DTILE_MISALIGN_CHK_EN
module dtile_mem_responder
  import dtile_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int LSID_W = DEFAULT_LSID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic [LSID_W-1:0] req_lsid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              set_complete,
  output logic [LSID_W-1:0] set_lsid,
  output logic [DATA_W-1:0] set_data,
`ifdef DTILE_MISALIGN_CHK_EN
  output logic              set_err,
`endif
  output logic              busy
);

  localparam int ENTRY_W = 1 + LSID_W + ADDR_W + DATA_W;

  dtile_rsp_state_e  state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [ENTRY_W-1:0] head;
  logic              head_is_load;
  logic [LSID_W-1:0] head_lsid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_misaligned;

  assign head_is_load = head[ENTRY_W-1];
  assign head_lsid    = head[ENTRY_W-2 -: LSID_W];
  assign head_addr    = head[DATA_W +: ADDR_W];
  assign head_data    = head[DATA_W-1:0];

`ifdef DTILE_MISALIGN_CHK_EN
  localparam int OFF_W = $clog2(DATA_W/8);
  assign head_misaligned = |head_addr[OFF_W-1:0];
`else
  assign head_misaligned = 1'b0;
`endif

  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  dtile_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid),
    .push_data ({req_is_load, req_lsid, req_addr, req_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Head leaves the queue when its access fully completes (or is rejected as misaligned)
  always_comb begin
    fifo_pop = 1'b0;
    if (state == ISSUE)
      fifo_pop = head_misaligned || (mem_gnt && !head_is_load);
    else if (state == WAIT_RD)
      fifo_pop = mem_rvalid;
  end

  // Access sequencer with registered memory port and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      set_complete <= 1'b0;
      set_lsid     <= '0;
      set_data     <= '0;
`ifdef DTILE_MISALIGN_CHK_EN
      set_err      <= 1'b0;
`endif
    end else begin
      set_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= ISSUE;
            mem_req   <= !head_misaligned;
            mem_we    <= !head_is_load && !head_misaligned;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
          end
        end
        ISSUE: begin
          if (head_misaligned) begin
            state        <= IDLE;
            set_complete <= 1'b1;
            set_lsid     <= head_lsid;
            set_data     <= '0;
`ifdef DTILE_MISALIGN_CHK_EN
            set_err      <= 1'b1;
`endif
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (head_is_load) begin
              state <= WAIT_RD;
            end else begin
              state        <= IDLE;
              set_complete <= 1'b1;
              set_lsid     <= head_lsid;
              set_data     <= '0;
`ifdef DTILE_MISALIGN_CHK_EN
              set_err      <= 1'b0;
`endif
            end
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            state        <= IDLE;
            set_complete <= 1'b1;
            set_lsid     <= head_lsid;
            set_data     <= mem_rdata;
`ifdef DTILE_MISALIGN_CHK_EN
            set_err      <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
